// File: rtl/debug_seg_display.sv
// Debug bus viewer: one 16-bit value as 4 hex digits on a scanned 7-seg display.
// Optional DP_STATE_EN: decimal points show captured CPU state bits and freeze.
module debug_seg_display #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sel,
    input  logic        freeze_btn,
    input  logic [7:0]  pc_dbg,
    input  logic [15:0] ir_dbg,
    input  logic [15:0] alu_out_dbg,
    input  logic [15:0] rs_val_dbg,
    input  logic [2:0]  state_dbg,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        held
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    logic [1:0]    sel_s1_q, sel_s2_q;
    logic          frz_s1_q, frz_s2_q, frz_s3_q;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          held_q, held_d;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          dp_q, dp_d;
    logic          tick, frz_edge, load;
    logic [15:0]   mux;
    logic [3:0]    nib;

`ifdef DP_STATE_EN
    logic [2:0]    sstate_q;
`else
    logic          unused_state;
    assign unused_state = ^state_dbg;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Scan timing, frame-aligned snapshot and freeze toggling
    always_comb begin
        tick     = (div_q == DIV_MAX);
        div_d    = tick ? '0 : div_q + 1'b1;
        digit_d  = tick ? digit_q + 2'd1 : digit_q;
        frz_edge = frz_s2_q & ~frz_s3_q;
        held_d   = held_q ^ frz_edge;
        load     = tick && (digit_q == 2'd3) && !held_q;
        case (sel_s2_q)
            2'd0:    mux = {8'h00, pc_dbg};
            2'd1:    mux = ir_dbg;
            2'd2:    mux = alu_out_dbg;
            default: mux = rs_val_dbg;
        endcase
        shadow_d = load ? mux : shadow_q;
        nib      = shadow_q[4*digit_q +: 4];
    end

    // Decimal point source for the digit being driven next
    always_comb begin
        dp_d = 1'b1;
`ifdef DP_STATE_EN
        case (digit_q)
            2'd0:    dp_d = ~sstate_q[0];
            2'd1:    dp_d = ~sstate_q[1];
            2'd2:    dp_d = ~sstate_q[2];
            default: dp_d = ~held_q;
        endcase
`endif
    end

    // All state: synchronisers, scan counters, snapshot and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_s1_q <= '0;
            sel_s2_q <= '0;
            frz_s1_q <= 1'b0;
            frz_s2_q <= 1'b0;
            frz_s3_q <= 1'b0;
            div_q    <= '0;
            digit_q  <= '0;
            shadow_q <= '0;
            held_q   <= 1'b0;
            seg_q    <= 7'h7F;
            an_q     <= 4'hF;
            dp_q     <= 1'b1;
`ifdef DP_STATE_EN
            sstate_q <= '0;
`endif
        end else begin
            sel_s1_q <= sel;
            sel_s2_q <= sel_s1_q;
            frz_s1_q <= freeze_btn;
            frz_s2_q <= frz_s1_q;
            frz_s3_q <= frz_s2_q;
            div_q    <= div_d;
            digit_q  <= digit_d;
            shadow_q <= shadow_d;
            held_q   <= held_d;
            seg_q    <= hex7(nib);
            an_q     <= ~(4'b0001 << digit_q);
            dp_q     <= dp_d;
`ifdef DP_STATE_EN
            if (load) sstate_q <= state_dbg;
`endif
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = dp_q;
    assign held = held_q;

endmodule

// File: tb/tb_debug_seg_display.sv
// Randomised and directed bench for debug_seg_display.
// Reference model works from frame arithmetic on an edge count since reset.
module tb_debug_seg_display;

    localparam int SD = 10;

    logic        clk = 0;
    logic        reset = 0;
    logic [1:0]  sel = 0;
    logic        freeze_btn = 0;
    logic [7:0]  pc_dbg = 0;
    logic [15:0] ir_dbg = 0;
    logic [15:0] alu_out_dbg = 0;
    logic [15:0] rs_val_dbg = 0;
    logic [2:0]  state_dbg = 0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        held;

    int n_pass = 0;
    int n_total = 0;

    debug_seg_display #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
        .clk(clk), .reset(reset), .sel(sel), .freeze_btn(freeze_btn),
        .pc_dbg(pc_dbg), .ir_dbg(ir_dbg), .alu_out_dbg(alu_out_dbg),
        .rs_val_dbg(rs_val_dbg), .state_dbg(state_dbg),
        .seg(seg), .an(an), .dp(dp), .held(held)
    );

    always #5 clk = ~clk;

    logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // reference model state
    int          m_cnt;
    logic [1:0]  s_h1, s_h2;
    logic        f_h1, f_h2, f_h3;
    logic [15:0] m_shadow;
    logic [2:0]  m_sst;
    logic        m_held;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_held;

    always @(posedge clk or negedge reset) begin
        int dg, dv;
        logic [15:0] src;
        if (!reset) begin
            m_cnt = 0; s_h1 = 0; s_h2 = 0;
            f_h1 = 0; f_h2 = 0; f_h3 = 0;
            m_shadow = 0; m_sst = 0; m_held = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1; e_held = 0;
        end else begin
            dg = (m_cnt / SD) % 4;
            dv = m_cnt % SD;
            e_an = 4'hF;
            e_an[dg] = 1'b0;
            e_seg = HEX[(m_shadow >> (4 * dg)) & 16'hF];
            e_dp = 1'b1;
`ifdef DP_STATE_EN
            e_dp = (dg == 3) ? !m_held : !m_sst[dg];
`endif
            case (s_h2)
                0: src = {8'h00, pc_dbg};
                1: src = ir_dbg;
                2: src = alu_out_dbg;
                default: src = rs_val_dbg;
            endcase
            if (dv == SD - 1 && dg == 3 && !m_held) begin
                m_shadow = src;
                m_sst = state_dbg;
            end
            if (f_h2 && !f_h3) m_held = !m_held;
            e_held = m_held;
            f_h3 = f_h2; f_h2 = f_h1; f_h1 = freeze_btn;
            s_h2 = s_h1; s_h1 = sel;
            m_cnt++;
        end
    end

    task automatic test_reset();
        reset = 0;
        repeat (3) begin
            @(posedge clk); #1;
            n_total++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || held !== 1'b0)
                $display("FAIL reset_hold an=%b seg=%b dp=%b held=%b want F/7F/1/0",
                         an, seg, dp, held);
            else n_pass++;
        end
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        n_total++;
        if (an !== 4'b1110 || seg !== 7'b1000000)
            $display("FAIL reset_first an=%b seg=%b want 1110/1000000", an, seg);
        else n_pass++;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp || held !== e_held)
                $display("FAIL reset_scan an=%b seg=%b dp=%b held=%b want %b/%b/%b/%b",
                         an, seg, dp, held, e_an, e_seg, e_dp, e_held);
            else n_pass++;
        end
    endtask

    task automatic test_alu_frame();
        logic [6:0] want;
        @(negedge clk);
        sel = 2; alu_out_dbg = 16'hA18F;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp || held !== e_held)
                $display("FAIL alu_scan an=%b seg=%b dp=%b held=%b want %b/%b/%b/%b",
                         an, seg, dp, held, e_an, e_seg, e_dp, e_held);
            else n_pass++;
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            case (e_an)
                4'b1110: want = 7'b0001110;
                4'b1101: want = 7'b0000000;
                4'b1011: want = 7'b1111001;
                default: want = 7'b0001000;
            endcase
            n_total++;
            if (an !== e_an || seg !== want)
                $display("FAIL alu_digits an=%b seg=%b want %b/%b", an, seg, e_an, want);
            else n_pass++;
        end
    endtask

    task automatic test_midframe();
        int guard;
        @(negedge clk); alu_out_dbg = 16'h1111;
        repeat (90) @(posedge clk);
        guard = 0;
        while (e_an !== 4'b1101 && guard < 60) begin
            @(posedge clk); #1; guard++;
        end
        n_total++;
        if (guard >= 60) $display("FAIL mid_wait digit1 not reached an=%b want 1101", an);
        else n_pass++;
        @(negedge clk); alu_out_dbg = 16'h8888;
        for (int i = 0; i < 90; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp || held !== e_held)
                $display("FAIL mid_scan an=%b seg=%b dp=%b held=%b want %b/%b/%b/%b",
                         an, seg, dp, held, e_an, e_seg, e_dp, e_held);
            else n_pass++;
        end
        n_total++;
        if (seg !== 7'b0000000)
            $display("FAIL mid_eights seg=%b want 0000000", seg);
        else n_pass++;
    endtask

    task automatic test_freeze();
        @(negedge clk); sel = 1; ir_dbg = 16'h00FF; pc_dbg = 8'h5A;
        repeat (60) @(posedge clk);
        @(negedge clk); freeze_btn = 1;
        repeat (3) @(negedge clk);
        freeze_btn = 0;
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (held !== 1'b1) $display("FAIL freeze_on held=%b want 1", held);
        else n_pass++;
        @(negedge clk); ir_dbg = 16'h1234; sel = 0;
        for (int i = 0; i < 90; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp || held !== e_held)
                $display("FAIL frz_scan an=%b seg=%b dp=%b held=%b want %b/%b/%b/%b",
                         an, seg, dp, held, e_an, e_seg, e_dp, e_held);
            else n_pass++;
            if (e_an == 4'b1110) begin
                n_total++;
                if (seg !== 7'b0001110) $display("FAIL frz_hold seg=%b want 0001110", seg);
                else n_pass++;
            end
        end
        @(negedge clk); freeze_btn = 1;
        repeat (3) @(negedge clk);
        freeze_btn = 0;
        for (int i = 0; i < 90; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp || held !== e_held)
                $display("FAIL rel_scan an=%b seg=%b dp=%b held=%b want %b/%b/%b/%b",
                         an, seg, dp, held, e_an, e_seg, e_dp, e_held);
            else n_pass++;
        end
        n_total++;
        if (held !== 1'b0) $display("FAIL freeze_off held=%b want 0", held);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (e_an == 4'b1110) begin
                n_total++;
                if (seg !== 7'b0001000) $display("FAIL rel_pc seg=%b want 0001000", seg);
                else n_pass++;
            end
        end
    endtask

    task automatic test_dp_state();
        logic want;
        @(negedge clk); state_dbg = 3'b101;
        repeat (60) @(posedge clk);
        @(negedge clk); freeze_btn = 1;
        repeat (3) @(negedge clk);
        freeze_btn = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
`ifdef DP_STATE_EN
            want = (e_an == 4'b1101);
`else
            want = 1'b1;
`endif
            n_total++;
            if (dp !== want || an !== e_an || dp !== e_dp || held !== e_held)
                $display("FAIL dp_state an=%b dp=%b held=%b want %b/%b/%b",
                         an, dp, held, e_an, want, e_held);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(e_an === 4'b1011 && e_held === 1'b1) && guard < 60) begin
            @(posedge clk); #1; guard++;
        end
        n_total++;
        if (guard >= 60) $display("FAIL rmid_wait an=%b held=%b want 1011/1", an, held);
        else n_pass++;
        #2 reset = 0;
        #1;
        n_total++;
        if (an !== 4'hF || seg !== 7'h7F || held !== 1'b0 || dp !== 1'b1)
            $display("FAIL rmid_async an=%b seg=%b held=%b dp=%b want F/7F/0/1",
                     an, seg, held, dp);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        n_total++;
        if (an !== 4'b1110 || seg !== 7'b1000000)
            $display("FAIL rmid_restart an=%b seg=%b want 1110/1000000", an, seg);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp || held !== e_held)
                $display("FAIL rmid_scan an=%b seg=%b dp=%b held=%b want %b/%b/%b/%b",
                         an, seg, dp, held, e_an, e_seg, e_dp, e_held);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int frz_left = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) pc_dbg = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ir_dbg = 16'($urandom);
            if ($urandom_range(0, 3) == 0) alu_out_dbg = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rs_val_dbg = 16'($urandom);
            if ($urandom_range(0, 7) == 0) state_dbg = 3'($urandom);
            if ($urandom_range(0, 29) == 0) sel = 2'($urandom);
            if (frz_left > 0) begin
                frz_left--;
                if (frz_left == 0) freeze_btn = 0;
            end else if ($urandom_range(0, 89) == 0) begin
                freeze_btn = 1;
                frz_left = $urandom_range(1, 6);
            end
            @(posedge clk); #1;
            n_total++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp || held !== e_held)
                $display("FAIL rand_scan an=%b seg=%b dp=%b held=%b want %b/%b/%b/%b",
                         an, seg, dp, held, e_an, e_seg, e_dp, e_held);
            else n_pass++;
        end
        @(negedge clk); freeze_btn = 0;
    endtask

    initial begin
        test_reset();
        test_alu_frame();
        test_midframe();
        test_freeze();
        test_dp_state();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
